result_drain: RTL
=================

Name: result_drain

Overview:
- Sits directly downstream of the pipelined RISC-V core and consumes what the core produces.
- When the core asserts done, it snapshots the core's clock_count and instr_count.
- It then reads the M×N2 result matrix out of data memory through a second read port.
- It emits header, result words and trailer as a valid/ready word stream toward the host or debug link.

Parameters:
- M, 10, rows of matrix A and of the result.
- N, 10, inner dimension.
- N2, 10, columns of matrix B and of the result.
- REG_WIDTH, 32, data-memory word width; must be ≤ 32.
- ADDR_W, 10, data-memory address width; must satisfy 2^ADDR_W ≥ M*N+N*N2+M*N2.

Ports:
- CLOCK_50  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- cpu_done  in  1  core finished (level).
- clock_count  in  32  core cycle counter.
- instr_count  in  32  core retired-instruction counter.
- mem_rd_en  out  1  data-memory read strobe.
- mem_addr  out  ADDR_W  data-memory read address.
- mem_rdata  in  REG_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
- out_valid  out  1  stream word valid.
- out_ready  in  1  stream sink ready.
- out_data  out  32  stream word.
- out_tag  out  2  word kind: 0 header, 1 data, 2 trailer.
- out_last  out  1  final word of stream.
- busy  out  1  drain in progress.
- drain_done  out  1  stream fully accepted.

Behaviour:
- Reset: rstn is synchronous, active-low, sampled on the CLOCK_50 rising edge. While it is low, all outputs are 0, the FSM is in IDLE, the buffer is emptied, and any in-flight read is discarded.
- FSM states: IDLE, HDR, DATA, TRL0, TRL1, FIN.
- IDLE: cpu_done=1 → latch clock_count and instr_count into snapshot registers that same edge, then go to HDR; busy=1 from the next cycle.
- HDR: out_valid=1, out_tag=0, out_data={8'hA5, M[7:0], N2[7:0], N[7:0]}.
  - Header appears the cycle after the trigger edge.
  - On handshake (out_valid & out_ready) go to DATA; the read index k resets to 0.
- DATA, read side:
  - Read k targets address RES_BASE+k, RES_BASE = M*N+N*N2, for k = 0..M*N2-1 in row-major order.
  - Reads feed a 2-entry FIFO.
  - Issue a read when k < M*N2 and (fifo_count + inflight − pop) < 2. This guarantees no overflow.
  - mem_rdata is pushed the cycle it returns. The FIFO head drives the output directly, so a read issued in cycle c is presented in cycle c+2.
- DATA, output side:
  - out_tag=1; out_data = mem_rdata zero-extended to 32.
  - With out_ready held high, data words appear on consecutive cycles.
  - After the handshake of word M*N2-1, go to TRL0.
- TRL0: out_tag=2, out_data = clock_count snapshot.
- TRL1: out_tag=2, out_data = instr_count snapshot, out_last=1. On handshake go to FIN.
- FIN:
  - drain_done=1, busy=0, out_valid=0.
  - Stays in FIN while cpu_done=1. When cpu_done=0, return to IDLE, re-armed; drain_done drops that cycle.
- Stream rules:
  - Once out_valid is asserted, out_data, out_tag and out_last are held stable until handshake.
  - out_valid is never withdrawn without a handshake.
  - There are no gaps caused by the drain itself, other than read latency at the start of DATA.
- Boundary conditions:
  - cpu_done falling mid-drain: ignored; the stream completes.
  - M*N2=1: exactly 4 words are emitted.
  - Counter values changing after the trigger: not reflected; snapshot only.
  - Simultaneous push and pop on a full FIFO: count unchanged.
  - Read index k saturates at M*N2; no wrap.
- Width: snapshots are 32 bits. The k counter is sized $clog2(M*N2+1).

Decomposition:
- Shared package riscv_pkg holds:
  - tag constants TAG_HDR/TAG_DATA/TAG_TRL;
  - header magic 8'hA5;
  - FSM state encoding;
  - RES_BASE expression as a function of M and N.
- One sub-module: drain_fifo, a 2-entry synchronous FIFO with push, pop, count, head and synchronous rstn clear.

Test Plan:
1. Hold rstn low 3 cycles with cpu_done=1 → all outputs 0; no stream starts until rstn=1, then the header appears the cycle after the first high-rstn edge.
2. Setup: M=N=N2=2; mem[8..11]=11,22,33,44; clock_count=100; instr_count=57; cpu_done rises; out_ready=1.
   → stream 0xA5020202(tag0), 11,22,33,44(tag1, consecutive cycles), 100, 57(tag2, last=1), then drain_done=1.
3. Same setup, out_ready low 20 cycles then toggling 1010 → identical word sequence with no loss or duplication; data stable while stalled; outstanding reads never exceed 2.
4. rstn pulsed low after the 2nd data handshake → out_valid=0 and busy=0 next cycle; re-trigger produces the full stream from header.
5. clock_count incremented every cycle during the drain → trailer shows the value at the trigger edge.
6. cpu_done held high after FIN → no second stream. Drop cpu_done, change instr_count to 90, re-raise cpu_done → second complete stream with trailer 90.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: constants shared between the core and its result drain.
//   TAG_*      word-kind codes carried on the drain stream's out_tag
//   HDR_MAGIC  top byte of the drain header word
//   S_*        drain FSM state encoding
//   res_base   first data-memory address of the result matrix
package riscv_pkg;
   localparam logic [1:0] TAG_HDR  = 2'd0;
   localparam logic [1:0] TAG_DATA = 2'd1;
   localparam logic [1:0] TAG_TRL  = 2'd2;
   localparam logic [7:0] HDR_MAGIC = 8'hA5;
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_HDR  = 3'd1;
   localparam logic [2:0] S_DATA = 3'd2;
   localparam logic [2:0] S_TRL0 = 3'd3;
   localparam logic [2:0] S_TRL1 = 3'd4;
   localparam logic [2:0] S_FIN  = 3'd5;
   // Memory holds A (m*n words), then B (n*n2 words), then the result.
   function automatic int res_base(input int m, input int n, input int n2);
      return m * n + n * n2;
   endfunction
endpackage

// File: rtl/drain_fifo.sv
// drain_fifo: 2-entry synchronous FIFO buffering data-memory read returns.
//   CLOCK_50/rstn  clock, synchronous active-low clear
//   push/din       write one word (ignored when full unless popping)
//   pop            drop the head word (ignored when empty)
//   count          occupancy 0..2
//   head           oldest word, valid while count != 0
module drain_fifo #(
   parameter int W = 32
) (
   input  logic         CLOCK_50,
   input  logic         rstn,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [1:0]   count,
   output logic [W-1:0] head
);
   logic [W-1:0] mem [2];
   logic wp, rp, do_push, do_pop;
   // A pop frees the slot in the same edge, so push+pop on a full FIFO is accepted.
   always_comb begin
      do_pop  = pop && count != 2'd0;
      do_push = push && (count != 2'd2 || do_pop);
   end
   assign head = mem[rp];
   always_ff @(posedge CLOCK_50) begin
      if (!rstn) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wp     <= 1'b0;
         rp     <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wp] <= din;
            wp      <= ~wp;
         end
         if (do_pop) rp <= ~rp;
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end
endmodule

// File: rtl/result_drain.sv
// result_drain: after the core finishes, streams header, result matrix and counter trailer.
//   CLOCK_50/rstn             clock, synchronous active-low reset
//   cpu_done                  core finished (level); rising level triggers one drain
//   clock_count/instr_count   core counters, snapshotted at the trigger edge
//   mem_rd_en/mem_addr        data-memory read port; mem_rdata returns one cycle later
//   out_valid/out_ready       stream handshake; out_data/out_tag/out_last word payload
//   busy                      drain in progress; drain_done stream fully accepted
module result_drain
   import riscv_pkg::*;
#(
   parameter int M         = 10,
   parameter int N         = 10,
   parameter int N2        = 10,
   parameter int REG_WIDTH = 32,
   parameter int ADDR_W    = 10
) (
   input  logic                 CLOCK_50,
   input  logic                 rstn,
   input  logic                 cpu_done,
   input  logic [31:0]          clock_count,
   input  logic [31:0]          instr_count,
   output logic                 mem_rd_en,
   output logic [ADDR_W-1:0]    mem_addr,
   input  logic [REG_WIDTH-1:0] mem_rdata,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_data,
   output logic [1:0]           out_tag,
   output logic                 out_last,
   output logic                 busy,
   output logic                 drain_done
);
   localparam int TOTAL = M * N2;
   localparam int KW = $clog2(TOTAL + 1);
   localparam logic [KW-1:0] K_END = KW'(TOTAL);
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(res_base(M, N, N2));
   localparam logic [31:0] HDR_WORD = {HDR_MAGIC, 8'(M), 8'(N2), 8'(N)};

   logic [2:0]           state;
   logic [31:0]          snap_cc, snap_ic;
   logic [KW-1:0]        k;
   logic                 inflight;
   logic [1:0]           fcount;
   logic [REG_WIDTH-1:0] fhead;
   logic [2:0]           occ;
   logic                 pop, issue, last_word, have_data;

   always_comb begin
      have_data = state == S_DATA && fcount != 2'd0;
      out_valid = state == S_HDR || state == S_TRL0 || state == S_TRL1 || have_data;
      pop       = have_data && out_ready;
      // Slots committed after this edge: buffered + returning - leaving. Keeping it
      // below 2 before issuing means a returning word always finds room.
      occ       = {1'b0, fcount} + {2'b0, inflight} - {2'b0, pop};
      issue     = state == S_DATA && k < K_END && occ < 3'd2;
      // All reads issued and returned, one word left: it is the final data word.
      last_word = k == K_END && !inflight && fcount == 2'd1;
      mem_rd_en = issue;
      mem_addr  = issue ? BASE + ADDR_W'(k) : '0;
      out_tag   = state == S_DATA ? TAG_DATA : (state == S_TRL0 || state == S_TRL1) ? TAG_TRL : TAG_HDR;
      out_data  = state == S_HDR  ? HDR_WORD :
                  have_data       ? 32'(fhead) :
                  state == S_TRL0 ? snap_cc :
                  state == S_TRL1 ? snap_ic : 32'd0;
      out_last   = state == S_TRL1;
      busy       = state == S_HDR || state == S_DATA || state == S_TRL0 || state == S_TRL1;
      drain_done = state == S_FIN;
   end

   always_ff @(posedge CLOCK_50) begin
      if (!rstn) begin
         state    <= S_IDLE;
         snap_cc  <= 32'd0;
         snap_ic  <= 32'd0;
         k        <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) k <= k + KW'(1);
         case (state)
            S_IDLE: if (cpu_done) begin
               snap_cc <= clock_count;
               snap_ic <= instr_count;
               state   <= S_HDR;
            end
            S_HDR: if (out_ready) begin
               k     <= '0;
               state <= S_DATA;
            end
            S_DATA: if (pop && last_word) state <= S_TRL0;
            S_TRL0: if (out_ready) state <= S_TRL1;
            S_TRL1: if (out_ready) state <= S_FIN;
            S_FIN:  if (!cpu_done) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   drain_fifo #(.W(REG_WIDTH)) u_fifo (
      .CLOCK_50 (CLOCK_50),
      .rstn     (rstn),
      .push     (inflight),
      .pop      (pop),
      .din      (mem_rdata),
      .count    (fcount),
      .head     (fhead)
   );
endmodule
